// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - size codes, FSM states and byte-lane helper for param_byte_ram
package ram_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_RSVD = 2'b10;
  localparam logic [1:0] SZ_WORD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } ramState_t;

  // Lanes are relative to the 4-byte window at the access address; lane 3 is
  // the byte at the address itself (MSB). All-zero means the access is rejected.
  function automatic logic [3:0] laneEnables(input logic [1:0] size, input logic [1:0] addrLow);
    case (size)
      SZ_BYTE: return 4'b1000;
      SZ_HALF: return addrLow[0] ? 4'b0000 : 4'b1100;
      SZ_WORD: return (addrLow != 2'b00) ? 4'b0000 : 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/ram_byte_array.sv
// rtl/ram_byte_array.sv - DEPTH x 8 storage with 4 byte-lane write enables and a 4-byte read window
module ram_byte_array #(
  parameter int DEPTH  = 512,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              Clk,
  input  logic [ADDR_W-1:0] addr,
  input  logic [3:0]        wrEn,
  input  logic [31:0]       wrData,
  output logic [31:0]       rdData
);

  logic [7:0] mem [DEPTH];

  // Window byte i lives at addr+i and maps to bits [31-8i -: 8]; addresses wrap.
  always_ff @(posedge Clk) begin
    for (int i = 0; i < 4; i++) begin
      if (wrEn[3-i]) begin
        mem[addr + ADDR_W'(i)] <= wrData[31-8*i -: 8];
      end
    end
  end

  for (genvar g = 0; g < 4; g++) begin : gRead
    assign rdData[31-8*g -: 8] = mem[addr + ADDR_W'(g)];
  end

endmodule

// File: rtl/param_byte_ram.sv
// rtl/param_byte_ram.sv - MFA/MFC big-endian byte RAM with wait states; MISALIGN_TRAP_EN traps unaligned accesses
module param_byte_ram
  import ram_pkg::*;
#(
  parameter int DEPTH       = 512,
  parameter int ADDR_W      = $clog2(DEPTH),
  parameter int WAIT_CYCLES = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              memFuncActive,
  input  logic              readWrite,
  input  logic [ADDR_W-1:0] address,
  input  logic [31:0]       dataIn,
  input  logic [1:0]        dataSize,
  output logic [31:0]       dataOut,
  output logic              memFuncComplete,
  output logic              memError
);

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  ramState_t         state, stateNext;
  logic [3:0]        cnt, cntNext;
  logic              capture, access;
  logic              rwQ;
  logic [ADDR_W-1:0] addrQ, effAddr;
  logic [31:0]       dataQ;
  logic [1:0]        sizeQ;
  logic [3:0]        lanes, wrEn;
  logic              reject;
  logic [31:0]       wrWindow, rdWindow, readVal;

`ifdef MISALIGN_TRAP_EN
  assign effAddr = addrQ;
`else
  always_comb begin
    effAddr = addrQ;
    if (sizeQ == SZ_HALF) begin
      effAddr[0] = 1'b0;
    end else if (sizeQ == SZ_WORD) begin
      effAddr[1:0] = 2'b00;
    end
  end
`endif

  assign lanes  = laneEnables(sizeQ, effAddr[1:0]);
  assign reject = (lanes == 4'b0000);
  // Reset on the access edge must win over the write.
  assign wrEn   = (access && rwQ && !reject && !Reset) ? lanes : 4'b0000;

  always_comb begin
    wrWindow = dataQ;
    readVal  = rdWindow;
    case (sizeQ)
      SZ_BYTE: begin
        wrWindow = {dataQ[7:0], 24'h0};
        readVal  = {24'h0, rdWindow[31:24]};
      end
      SZ_HALF: begin
        wrWindow = {dataQ[15:0], 16'h0};
        readVal  = {16'h0, rdWindow[31:16]};
      end
      default: ;
    endcase
  end

  ram_byte_array #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) uArray (
    .Clk   (Clk),
    .addr  (effAddr),
    .wrEn  (wrEn),
    .wrData(wrWindow),
    .rdData(rdWindow)
  );

  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    capture   = 1'b0;
    access    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (memFuncActive) begin
          capture   = 1'b1;
          cntNext   = WAIT_INIT;
          stateNext = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (cnt != 4'd0) begin
          cntNext = cnt - 4'd1;
        end else begin
          access    = 1'b1;
          stateNext = ST_DONE;
        end
      end
      ST_DONE: begin
        if (!memFuncActive) begin
          stateNext = ST_IDLE;
        end
      end
      default: stateNext = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state           <= ST_IDLE;
      cnt             <= 4'd0;
      dataOut         <= 32'h0;
      memFuncComplete <= 1'b0;
      memError        <= 1'b0;
      rwQ             <= 1'b0;
      addrQ           <= '0;
      dataQ           <= 32'h0;
      sizeQ           <= SZ_BYTE;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
      if (capture) begin
        rwQ   <= readWrite;
        addrQ <= address;
        dataQ <= dataIn;
        sizeQ <= dataSize;
      end
      if (access) begin
        memFuncComplete <= 1'b1;
        memError        <= reject;
        if (!rwQ && !reject) begin
          dataOut <= readVal;
        end
      end else if (state == ST_DONE && !memFuncActive) begin
        memFuncComplete <= 1'b0;
        memError        <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_param_byte_ram.sv
// tb/tb_param_byte_ram.sv - directed and randomized checks of param_byte_ram against a byte-array model
module tb_param_byte_ram;

  localparam int DEPTH  = 512;
  localparam int ADDR_W = 9;
  localparam int WAITC  = 2;
  localparam int LAT    = WAITC + 2;

  logic              Clk = 1'b0;
  logic              Reset;
  logic              memFuncActive;
  logic              readWrite;
  logic [ADDR_W-1:0] address;
  logic [31:0]       dataIn;
  logic [1:0]        dataSize;
  logic [31:0]       dataOut;
  logic              memFuncComplete;
  logic              memError;

  param_byte_ram #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .WAIT_CYCLES(WAITC)) dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .memFuncActive  (memFuncActive),
    .readWrite      (readWrite),
    .address        (address),
    .dataIn         (dataIn),
    .dataSize       (dataSize),
    .dataOut        (dataOut),
    .memFuncComplete(memFuncComplete),
    .memError       (memError)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  logic [7:0]  refMem [DEPTH];
  logic [31:0] refOut;

  int          lat;
  logic        gotErr, expErr;
  logic [31:0] gotOut;

  // Reference: bytes are laid out MSB-first from the (possibly aligned) base.
  task automatic modelAccess(input logic rw, input int a, input logic [31:0] d, input logic [1:0] sz,
                             output logic e);
    int n, base;
    n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : (sz == 2'b11) ? 4 : 0;
    e = 1'b1;
    if (n == 0) return;
`ifdef MISALIGN_TRAP_EN
    if (a % n != 0) return;
    base = a;
`else
    base = a - (a % n);
`endif
    e = 1'b0;
    if (rw) begin
      for (int i = 0; i < n; i++) refMem[(base + i) % DEPTH] = 8'(d >> (8 * (n - 1 - i)));
    end else begin
      refOut = 32'h0;
      for (int i = 0; i < n; i++) refOut = (refOut << 8) | 32'(refMem[(base + i) % DEPTH]);
    end
  endtask

  task automatic runAccess(input logic rw, input int a, input logic [31:0] d, input logic [1:0] sz);
    readWrite = rw; address = ADDR_W'(a); dataIn = d; dataSize = sz; memFuncActive = 1'b1;
    lat = 0;
    do begin
      @(posedge Clk); #1; lat++;
      readWrite = 1'($urandom); address = ADDR_W'($urandom); dataIn = $urandom; dataSize = 2'($urandom);
    end while (!memFuncComplete && lat < 50);
    gotErr = memError; gotOut = dataOut;
    memFuncActive = 1'b0;
    @(posedge Clk); #1;
  endtask

  task automatic doOp(input logic rw, input int a, input logic [31:0] d, input logic [1:0] sz);
    runAccess(rw, a, d, sz);
    modelAccess(rw, a, d, sz, expErr);
  endtask

  task automatic test_reset;
    Reset = 1'b1; memFuncActive = 1'b0; readWrite = 1'b0; address = '0; dataIn = '0; dataSize = 2'b00;
    repeat (2) @(posedge Clk);
    #1; Reset = 1'b0;
    refOut = 32'h0;
    checks++;
    if (dataOut !== 32'h0 || memFuncComplete !== 1'b0 || memError !== 1'b0) begin
      errors++; $display("FAIL reset: dataOut=%h mfc=%b err=%b, want 0 0 0", dataOut, memFuncComplete, memError);
    end
  endtask

  task automatic test_word;
    doOp(1'b1, 0, 32'hAABBCCDD, 2'b11);
    checks++;
    if (lat !== LAT || gotErr !== 1'b0) begin
      errors++; $display("FAIL word_write: lat=%0d err=%b, want %0d 0", lat, gotErr, LAT);
    end
    doOp(1'b0, 0, 32'h0, 2'b11);
    checks++;
    if (gotOut !== 32'hAABBCCDD || lat !== LAT || gotErr !== 1'b0) begin
      errors++; $display("FAIL word_read: out=%h lat=%0d err=%b, want aabbccdd %0d 0", gotOut, lat, gotErr, LAT);
    end
  endtask

  task automatic test_half_byte;
    doOp(1'b1, 4, 32'h11EEFFAA, 2'b01);
    doOp(1'b0, 4, 32'h0, 2'b01);
    checks++;
    if (gotOut !== 32'h0000FFAA) begin errors++; $display("FAIL half_read: out=%h want 0000ffaa", gotOut); end
    doOp(1'b0, 4, 32'h0, 2'b00);
    checks++;
    if (gotOut !== 32'h000000FF) begin errors++; $display("FAIL byte_read4: out=%h want 000000ff", gotOut); end
    doOp(1'b0, 5, 32'h0, 2'b00);
    checks++;
    if (gotOut !== 32'h000000AA) begin errors++; $display("FAIL byte_read5: out=%h want 000000aa", gotOut); end
  endtask

  task automatic test_byte_merge;
    doOp(1'b1, 1, 32'h11EEFF22, 2'b00);
    doOp(1'b0, 0, 32'h0, 2'b11);
    checks++;
    if (gotOut !== 32'hAA22CCDD) begin errors++; $display("FAIL byte_merge: out=%h want aa22ccdd", gotOut); end
  endtask

  task automatic test_errors;
    logic [31:0] prev;
    prev = dataOut;
    doOp(1'b0, 2, 32'h0, 2'b11);
    checks++;
`ifdef MISALIGN_TRAP_EN
    if (gotErr !== 1'b1 || gotOut !== prev || lat !== LAT) begin
      errors++; $display("FAIL misalign: err=%b out=%h lat=%0d, want 1 %h %0d", gotErr, gotOut, lat, prev, LAT);
    end
`else
    if (gotErr !== 1'b0 || gotOut !== 32'hAA22CCDD || lat !== LAT) begin
      errors++; $display("FAIL misalign: err=%b out=%h lat=%0d, want 0 aa22ccdd %0d", gotErr, gotOut, lat, LAT);
    end
`endif
    prev = dataOut;
    doOp(1'b0, 0, 32'h0, 2'b10);
    checks++;
    if (gotErr !== 1'b1 || gotOut !== prev || lat !== LAT) begin
      errors++; $display("FAIL reserved_size: err=%b out=%h lat=%0d, want 1 %h %0d", gotErr, gotOut, lat, prev, LAT);
    end
  endtask

  task automatic test_reset_abort;
    int mfcSeen;
    doOp(1'b1, 8, 32'h12345678, 2'b11);
    for (int edgeN = 2; edgeN <= 4; edgeN += 2) begin
      // Reset during BUSY (edge 2) and exactly on the access edge (edge 4)
      readWrite = 1'b1; address = 9'd8; dataIn = 32'hFFFFFFFF; dataSize = 2'b11; memFuncActive = 1'b1;
      repeat (edgeN - 1) begin @(posedge Clk); #1; end
      Reset = 1'b1;
      @(posedge Clk); #1;
      Reset = 1'b0; memFuncActive = 1'b0;
      refOut = 32'h0;
      mfcSeen = 0;
      repeat (4) begin
        if (memFuncComplete) mfcSeen++;
        @(posedge Clk); #1;
      end
      checks++;
      if (mfcSeen !== 0 || dataOut !== 32'h0 || memError !== 1'b0) begin
        errors++; $display("FAIL reset_abort_e%0d: mfcCycles=%0d out=%h err=%b, want 0 0 0", edgeN, mfcSeen, dataOut, memError);
      end
    end
    doOp(1'b0, 8, 32'h0, 2'b11);
    checks++;
    if (gotOut !== 32'h12345678) begin errors++; $display("FAIL reset_nowrite: out=%h want 12345678", gotOut); end
  endtask

  task automatic test_handshake;
    int hi, lo;
    logic [31:0] d1, d2;
    d1 = $urandom;
    readWrite = 1'b1; address = 9'd16; dataIn = d1; dataSize = 2'b11; memFuncActive = 1'b1;
    @(posedge Clk); #1;
    memFuncActive = 1'b0; dataIn = ~d1; address = 9'd20;
    hi = 0;
    repeat (10) begin @(posedge Clk); #1; if (memFuncComplete) hi++; end
    modelAccess(1'b1, 16, d1, 2'b11, expErr);
    checks++;
    if (hi !== 1) begin errors++; $display("FAIL mfa_drop_pulse: mfcCycles=%0d want 1", hi); end
    doOp(1'b0, 16, 32'h0, 2'b11);
    checks++;
    if (gotOut !== d1 || lat !== LAT) begin
      errors++; $display("FAIL after_drop_read: out=%h lat=%0d, want %h %0d", gotOut, lat, d1, LAT);
    end

    d2 = $urandom;
    readWrite = 1'b1; address = 9'd20; dataIn = d2; dataSize = 2'b11; memFuncActive = 1'b1;
    hi = 0;
    while (!memFuncComplete && hi < 50) begin @(posedge Clk); #1; hi++; end
    modelAccess(1'b1, 20, d2, 2'b11, expErr);
    dataIn = ~d2;
    lo = 0;
    repeat (8) begin @(posedge Clk); #1; if (!memFuncComplete) lo++; end
    memFuncActive = 1'b0;
    @(posedge Clk); #1;
    checks++;
    if (hi !== LAT || lo !== 0 || memFuncComplete !== 1'b0) begin
      errors++; $display("FAIL mfa_held: lat=%0d lowCycles=%0d mfcAfter=%b, want %0d 0 0", hi, lo, memFuncComplete, LAT);
    end
    doOp(1'b0, 20, 32'h0, 2'b11);
    checks++;
    if (gotOut !== d2) begin errors++; $display("FAIL held_no_rewrite: out=%h want %h", gotOut, d2); end
  endtask

  task automatic test_random;
    logic rw;
    int a;
    logic [31:0] d;
    logic [1:0] sz;
    for (int i = 0; i < DEPTH / 4; i++) begin
      d = $urandom;
      doOp(1'b1, 4 * i, d, 2'b11);
      checks++;
      if (gotErr !== 1'b0 || lat !== LAT) begin
        errors++; $display("FAIL fill[%0d]: err=%b lat=%0d, want 0 %0d", i, gotErr, lat, LAT);
      end
    end
    for (int i = 0; i < 300; i++) begin
      rw = 1'($urandom); a = int'($urandom_range(DEPTH - 1, 0)); d = $urandom; sz = 2'($urandom);
      doOp(rw, a, d, sz);
      checks++;
      if (gotErr !== expErr || gotOut !== refOut || lat !== LAT || memFuncComplete !== 1'b0) begin
        errors++;
        $display("FAIL random[%0d] rw=%b a=%0d sz=%b: err=%b out=%h lat=%0d mfc=%b, want %b %h %0d 0",
                 i, rw, a, sz, gotErr, gotOut, lat, memFuncComplete, expErr, refOut, LAT);
      end
    end
  endtask

  initial begin
    test_reset;
    test_word;
    test_half_byte;
    test_byte_merge;
    test_errors;
    test_reset_abort;
    test_handshake;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
